// File: rtl/ring_pkg.sv
// ring_pkg
// Shared definitions for the ring counter and the blocks that consume its
// one-hot phase bus.
//   RING_N      : phase count of the ring counter
//   mon_state_t : lock state machine encoding of ring_phase_monitor
//   rot1()      : one-place rotation of a RING_N-bit vector
package ring_pkg;

    localparam int RING_N = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCKED = 2'd1,
        ERROR  = 2'd2
    } mon_state_t;

    // dir=0 moves the set bit towards the MSB (idx+1), dir=1 towards the LSB.
    function automatic logic [RING_N-1:0] rot1(input logic [RING_N-1:0] vec,
                                               input logic              dir);
        if (dir) begin
            return {vec[0], vec[RING_N-1:1]};
        end
        return {vec[RING_N-2:0], vec[RING_N-1]};
    endfunction

endpackage

// File: rtl/ring_phase_monitor_if.sv
// ring_phase_monitor_if
// Bundles the phase bus from the ring counter, the error clear and the
// monitor status outputs.
//   master : drives ring_in/clr_err, observes status (producer/diagnostics side)
//   slave  : the monitor itself
interface ring_phase_monitor_if #(
    parameter int N     = ring_pkg::RING_N,
    parameter int IDX_W = $clog2(N),
    parameter int REV_W = 8,
    parameter int ERR_W = 4
);
    logic [N-1:0]     ring_in;
    logic             clr_err;
    logic [IDX_W-1:0] phase_idx;
    logic             phase_valid;
    logic             locked;
    logic             rev_pulse;
    logic [REV_W-1:0] rev_cnt;
    logic             err_pulse;
    logic             err_sticky;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output ring_in, clr_err,
        input  phase_idx, phase_valid, locked, rev_pulse, rev_cnt,
               err_pulse, err_sticky, err_cnt
    );

    modport slave (
        input  ring_in, clr_err,
        output phase_idx, phase_valid, locked, rev_pulse, rev_cnt,
               err_pulse, err_sticky, err_cnt
    );
endinterface

// File: rtl/ring_phase_monitor_onehot_enc.sv
// onehot_enc
// Combinational one-hot to binary encoder.
//   vec   : N-bit input vector
//   idx   : position of the set bit (meaningful only when valid=1)
//   valid : vec has exactly one bit set
module onehot_enc #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = i[IDX_W-1:0];
            end
        end
        valid = $onehot(vec);
    end
endmodule

// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor
// Checks the one-hot phase bus of a ring counter: encodes the phase, verifies
// every transition is a single-step rotation, runs a SEARCH/LOCKED/ERROR lock
// machine, counts revolutions and records sequence errors.
//   clk  : system clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : ring_in/clr_err in; phase_idx, phase_valid, locked, rev_pulse,
//          rev_cnt, err_pulse, err_sticky, err_cnt out (all registered)
//
// state  | meaning
// SEARCH | counting consecutive legal steps towards lock
// LOCKED | sequence trusted; illegal step flags an error, wraps count revs
// ERROR  | one-cycle lock loss after an error; input evaluated as in SEARCH
module ring_phase_monitor
    import ring_pkg::*;
#(
    parameter int N          = RING_N,
    parameter int IDX_W      = $clog2(N),
    parameter int DIR        = 0,
    parameter int ALLOW_HOLD = 0,
    parameter int LOCK_CNT   = 4,
    parameter int REV_W      = 8,
    parameter int ERR_W      = 4
) (
    input logic                clk,
    input logic                rstn,
    ring_phase_monitor_if.slave bus
);
    localparam int CNT_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CNT - 1);

    logic [N-1:0]     prev_q;
    logic             have_prev;
    logic [CNT_W-1:0] step_cnt, step_d;
    mon_state_t       state, state_d;

    logic [IDX_W-1:0] phase_idx_q;
    logic             phase_valid_q;
    logic             locked_q;
    logic             rev_pulse_q;
    logic [REV_W-1:0] rev_cnt_q;
    logic             err_pulse_q;
    logic             err_sticky_q;
    logic [ERR_W-1:0] err_cnt_q;

    logic [IDX_W-1:0] in_idx;
    logic             in_valid;
    logic [N-1:0]     rot_prev;
    logic             is_step, is_hold, legal, illegal, progress, wrap;
    logic             err_evt, rev_evt;

    onehot_enc #(.N(N), .IDX_W(IDX_W)) u_enc (
        .vec   (bus.ring_in),
        .idx   (in_idx),
        .valid (in_valid)
    );

    generate
        if (N == RING_N) begin : g_pkg_rot
            assign rot_prev = rot1(prev_q, DIR != 0);
        end else if (DIR == 0) begin : g_rot_up
            assign rot_prev = {prev_q[N-2:0], prev_q[N-1]};
        end else begin : g_rot_dn
            assign rot_prev = {prev_q[0], prev_q[N-1:1]};
        end
    endgenerate

    // A rotation of a one-hot prev_q is itself one-hot, so matching it
    // already implies ring_in is one-hot; the explicit terms keep 0000 safe.
    assign is_step  = in_valid && $onehot(prev_q) && (bus.ring_in == rot_prev);
    assign is_hold  = in_valid && (bus.ring_in == prev_q);
    assign legal    = is_step || ((ALLOW_HOLD != 0) && is_hold);
    assign illegal  = have_prev && !legal;
    assign progress = have_prev && is_step;
    assign wrap     = (DIR == 0) ? bus.ring_in[0] : bus.ring_in[N-1];

    always_comb begin
        state_d = state;
        step_d  = step_cnt;
        err_evt = 1'b0;
        rev_evt = 1'b0;
        if (have_prev) begin
            case (state)
                LOCKED: begin
                    if (illegal) begin
                        state_d = ERROR;
                        step_d  = '0;
                        err_evt = 1'b1;
                    end else if (progress && wrap) begin
                        rev_evt = 1'b1;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    if (progress) begin
                        if (step_cnt == LOCK_LAST) begin
                            state_d = LOCKED;
                            step_d  = '0;
                        end else begin
                            step_d = step_cnt + CNT_W'(1);
                        end
                    end else if (illegal) begin
                        step_d = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_q        <= '0;
            have_prev     <= 1'b0;
            step_cnt      <= '0;
            state         <= SEARCH;
            phase_idx_q   <= '0;
            phase_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            rev_pulse_q   <= 1'b0;
            rev_cnt_q     <= '0;
            err_pulse_q   <= 1'b0;
            err_sticky_q  <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            prev_q        <= bus.ring_in;
            have_prev     <= 1'b1;
            step_cnt      <= step_d;
            state         <= state_d;
            locked_q      <= (state_d == LOCKED);
            phase_valid_q <= in_valid;
            if (in_valid) begin
                phase_idx_q <= in_idx;
            end
            rev_pulse_q <= rev_evt;
            if (rev_evt) begin
                rev_cnt_q <= rev_cnt_q + REV_W'(1);
            end
            err_pulse_q <= err_evt;
            // An error on the clearing edge still gets recorded as the first one.
            if (err_evt) begin
                err_sticky_q <= 1'b1;
                if (bus.clr_err) begin
                    err_cnt_q <= ERR_W'(1);
                end else if (!(&err_cnt_q)) begin
                    err_cnt_q <= err_cnt_q + ERR_W'(1);
                end
            end else if (bus.clr_err) begin
                err_sticky_q <= 1'b0;
                err_cnt_q    <= '0;
            end
        end
    end

    assign bus.phase_idx   = phase_idx_q;
    assign bus.phase_valid = phase_valid_q;
    assign bus.locked      = locked_q;
    assign bus.rev_pulse   = rev_pulse_q;
    assign bus.rev_cnt     = rev_cnt_q;
    assign bus.err_pulse   = err_pulse_q;
    assign bus.err_sticky  = err_sticky_q;
    assign bus.err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb_ring_phase_monitor
// Directed bench for ring_phase_monitor (N=4, DIR=0, ALLOW_HOLD=0, LOCK_CNT=4).
module tb_ring_phase_monitor;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ring_phase_monitor_if #(.N(4), .IDX_W(2), .REV_W(8), .ERR_W(4)) bus ();

    ring_phase_monitor #(
        .N(4), .IDX_W(2), .DIR(0), .ALLOW_HOLD(0),
        .LOCK_CNT(4), .REV_W(8), .ERR_W(4)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input int valid,
                           input int lck, input int revp, input int revc,
                           input int errp, input int errs, input int errc);
        chk({tag, ".phase_idx"},   32'(bus.phase_idx),   idx);
        chk({tag, ".phase_valid"}, 32'(bus.phase_valid), valid);
        chk({tag, ".locked"},      32'(bus.locked),      lck);
        chk({tag, ".rev_pulse"},   32'(bus.rev_pulse),   revp);
        chk({tag, ".rev_cnt"},     32'(bus.rev_cnt),     revc);
        chk({tag, ".err_pulse"},   32'(bus.err_pulse),   errp);
        chk({tag, ".err_sticky"},  32'(bus.err_sticky),  errs);
        chk({tag, ".err_cnt"},     32'(bus.err_cnt),     errc);
    endtask

    task automatic step(input logic [3:0] v);
        bus.ring_in = v;
        @(posedge clk);
        #1;
    endtask

    // From an illegal prev sample: 0001 is unchecked-illegal, then 4 legal steps.
    task automatic relock(input string tag);
        step(4'b0001);
        step(4'b0010);
        step(4'b0100);
        step(4'b1000);
        chk({tag, ".pre_lock"}, 32'(bus.locked), 0);
        step(4'b0001);
        chk({tag, ".locked"}, 32'(bus.locked), 1);
    endtask

    initial begin
        bus.ring_in = '0;
        bus.clr_err = 1'b0;

        // reset then lock
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        rstn = 1'b1;
        step(4'b0001); chk_all("lk0", 0, 1, 0, 0, 0, 0, 0, 0);
        step(4'b0010); chk_all("lk1", 1, 1, 0, 0, 0, 0, 0, 0);
        step(4'b0100); chk_all("lk2", 2, 1, 0, 0, 0, 0, 0, 0);
        step(4'b1000); chk_all("lk3", 3, 1, 0, 0, 0, 0, 0, 0);
        step(4'b0001); chk_all("lk4", 0, 1, 1, 0, 0, 0, 0, 0);

        // revolutions
        for (int r = 0; r < 3; r++) begin
            step(4'b0010);
            step(4'b0100);
            step(4'b1000);
            chk("rev.no_pulse", 32'(bus.rev_pulse), 0);
            step(4'b0001);
            chk("rev.pulse", 32'(bus.rev_pulse), 1);
            chk("rev.cnt", 32'(bus.rev_cnt), r + 1);
        end
        for (int r = 3; r < 255; r++) begin
            step(4'b0010);
            step(4'b0100);
            step(4'b1000);
            step(4'b0001);
        end
        chk("rev.cnt255", 32'(bus.rev_cnt), 255);
        step(4'b0010);
        step(4'b0100);
        step(4'b1000);
        step(4'b0001);
        chk_all("rev.wrap", 0, 1, 1, 1, 0, 0, 0, 0);

        // skip error: 0001 -> 0010 -> 1000
        step(4'b0010); chk_all("skip.ok", 1, 1, 1, 0, 0, 0, 0, 0);
        step(4'b1000); chk_all("skip.err", 3, 1, 0, 0, 0, 1, 1, 1);
        step(4'b0001); chk_all("skip.errst", 0, 1, 0, 0, 0, 0, 1, 1);
        step(4'b0010); chk("skip.s2", 32'(bus.locked), 0);
        step(4'b0100); chk("skip.s3", 32'(bus.locked), 0);
        step(4'b1000); chk_all("skip.relock", 3, 1, 1, 0, 0, 0, 1, 1);

        // illegal codes
        step(4'b0000); chk_all("zero", 3, 0, 0, 0, 0, 1, 1, 2);
        step(4'b0001); chk_all("zero.next", 0, 1, 0, 0, 0, 0, 1, 2);
        step(4'b0010);
        step(4'b0100);
        step(4'b1000);
        chk("zero.pre_lock", 32'(bus.locked), 0);
        step(4'b0001); chk("zero.relock", 32'(bus.locked), 1);
        step(4'b0110); chk_all("multi", 0, 0, 0, 0, 0, 1, 1, 3);
        relock("multi");

        // saturation: errors 4..20
        for (int n = 4; n <= 20; n++) begin
            step(4'b0000);
            chk("sat.pulse", 32'(bus.err_pulse), 1);
            chk("sat.cnt", 32'(bus.err_cnt), (n > 15) ? 15 : n);
            relock("sat");
        end
        chk("sat.final", 32'(bus.err_cnt), 15);

        // clr_err alone, then colliding with an error
        bus.clr_err = 1'b1;
        step(4'b0010);
        bus.clr_err = 1'b0;
        chk_all("clr", 1, 1, 1, 0, 0, 0, 0, 0);
        bus.clr_err = 1'b1;
        step(4'b1000);
        bus.clr_err = 1'b0;
        chk_all("clr.coll", 3, 1, 0, 0, 0, 1, 1, 1);
        step(4'b0001);
        step(4'b0010);
        step(4'b0100); chk("coll.s3", 32'(bus.locked), 0);
        step(4'b1000); chk("coll.relock", 32'(bus.locked), 1);

        // five revolutions, then async reset between edges
        for (int r = 1; r <= 5; r++) begin
            step(4'b0001);
            chk("rev5.pulse", 32'(bus.rev_pulse), 1);
            if (r < 5) begin
                step(4'b0010);
                step(4'b0100);
                step(4'b1000);
            end
        end
        chk_all("rev5", 0, 1, 1, 1, 5, 0, 1, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk_all("async", 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(4'b0100); chk_all("post.first", 2, 1, 0, 0, 0, 0, 0, 0);
        step(4'b1000);
        step(4'b0001);
        step(4'b0010); chk("post.s3", 32'(bus.locked), 0);
        step(4'b0100); chk_all("post.lock", 2, 1, 1, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ring_phase_monitor.md
Name: ring_phase_monitor

Overview:
- Sits directly downstream of the 4-bit one-hot ring counter and consumes its `out` bus.
- Encodes the active one-hot phase to a binary index and checks every transition for a legal single-step rotation.
- Runs a lock state machine, counts completed revolutions, and records sequence errors.
- Its outputs feed phase-select and diagnostic logic.

Parameters:
- N, 4: ring width (number of phases), N >= 2.
- IDX_W, $clog2(N): width of the phase index.
- DIR, 0: rotation direction. 0 = expected next phase is idx+1 mod N; 1 = idx-1 mod N.
- ALLOW_HOLD, 0: 1 = an unchanged input is legal but is not progress; 0 = an unchanged input is an error.
- LOCK_CNT, 4: consecutive legal steps needed to reach LOCKED.
- REV_W, 8: revolution counter width.
- ERR_W, 4: error counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- ring_in  input  N  one-hot phase bus from the ring counter.
- clr_err  input  1  synchronous clear of err_sticky and err_cnt.
- phase_idx  output  IDX_W  binary index of the last sampled ring_in.
- phase_valid  output  1  last sampled ring_in was exactly one-hot.
- locked  output  1  FSM is in LOCKED.
- rev_pulse  output  1  one-cycle pulse on each wrap while LOCKED.
- rev_cnt  output  REV_W  revolution count; wraps modulo 2^REV_W.
- err_pulse  output  1  one-cycle pulse on each illegal transition while LOCKED.
- err_sticky  output  1  latched error flag.
- err_cnt  output  ERR_W  error count; saturates at all-ones.

Behaviour:
- Sampling and latency
  - All outputs are registered.
  - ring_in sampled at edge t appears on phase_idx, phase_valid, locked and the pulses after edge t, i.e. 1-cycle latency.
  - ring_in is not synchronised; the producer is in the clk domain.
- Internal state
  - prev_q: previous ring_in.
  - have_prev: first sample taken since reset.
  - step_cnt: consecutive legal steps.
- Reset (rstn low, async)
  - phase_idx=0, phase_valid=0, locked=0, rev_pulse=0, rev_cnt=0, err_pulse=0, err_sticky=0, err_cnt=0.
  - prev_q=0, have_prev=0, step_cnt=0, FSM=SEARCH.
- Encoding
  - one_hot = popcount(ring_in)==1.
  - If one_hot, phase_idx = position of the set bit.
  - Otherwise phase_idx holds its previous value and phase_valid=0.
- Legal transition (evaluated only when have_prev=1)
  - The transition is legal when ring_in is one-hot, prev_q is one-hot, and ring_in equals prev_q rotated one place in direction DIR, with wrap between bit N-1 and bit 0.
  - ring_in == prev_q is legal only if ALLOW_HOLD=1; it does not change step_cnt.
  - Every other case is illegal, including all-zero and multi-hot inputs.
- First sample after reset: sets have_prev=1; no check is made.
- FSM
  - SEARCH
    - A legal step increments step_cnt.
    - Reaching LOCK_CNT moves to LOCKED on that edge, so locked=1 on the next cycle.
    - An illegal transition clears step_cnt.
    - No error is flagged in SEARCH.
  - LOCKED
    - A legal step stays in LOCKED.
    - An illegal transition moves to ERROR and asserts err_pulse for one cycle.
    - err_sticky is set; err_cnt increments and saturates.
  - ERROR
    - Lasts exactly one cycle with locked=0 and step_cnt cleared, then goes to SEARCH.
    - The input during ERROR is evaluated as in SEARCH: a legal step counts toward step_cnt.
- Revolutions
  - While LOCKED and the step is legal, a wrap (phase index N-1 to 0 for DIR=0, 0 to N-1 for DIR=1) pulses rev_pulse and increments rev_cnt.
  - rev_cnt wraps from all-ones to 0.
  - rev_cnt is not cleared by loss of lock.
- clr_err
  - Clears err_sticky and err_cnt on the next edge.
  - If an error occurs on the same edge, the error wins: err_sticky=1, err_cnt=1.
- Reset mid-operation
  - Outputs return to reset values immediately, asynchronously.
  - After rstn rises, the first edge is treated as the first sample.

Decomposition:
- Shared package ring_pkg holds:
  - typedef enum logic [1:0] {SEARCH, LOCKED, ERROR} mon_state_t;
  - the constant RING_N=4, shared with the ring counter;
  - a function rot1(vec, dir) returning the one-place rotation.
- One sub-module is natural: onehot_enc (combinational; N-bit one-hot to index plus a valid flag). It is reusable by other phase consumers.
- The FSM, counters and checks stay in the top module.

Test Plan (N=4, DIR=0, ALLOW_HOLD=0, LOCK_CNT=4):
- Reset then lock
  - Stimulus: hold rstn=0 for 2 cycles; release; drive 0001, 0010, 0100, 1000, 0001, rotating each cycle.
  - Required: locked=1 one cycle after the 4th legal step; phase_idx tracks 0,1,2,3,0 with 1-cycle latency; all error outputs stay 0.
- Revolution count
  - Stimulus: while locked, run 3 full rotations.
  - Required: rev_pulse asserted on each 1000→0001 step; rev_cnt=3.
  - Also preload to 255 and do one more wrap: rev_cnt=0.
- Skip error
  - Stimulus: while locked, drive 0010 then 1000.
  - Required: err_pulse for one cycle, err_sticky=1, err_cnt=1, locked=0; ERROR for one cycle then SEARCH.
  - Relock after 4 legal steps.
- Illegal codes
  - Stimulus: drive 0000 and 0110 while locked.
  - Required: phase_valid=0, phase_idx held, err_cnt increments per event.
  - 20 forced errors: err_cnt saturates at 15.
- clr_err collision
  - Stimulus: assert clr_err alone; then assert it on the same edge as an illegal step.
  - Required: alone → err_sticky=0, err_cnt=0; collision → err_sticky=1, err_cnt=1.
- Async reset mid-run
  - Stimulus: pull rstn low between edges while locked with rev_cnt=5.
  - Required: all outputs go to 0 immediately without a clock edge; the first sample after release is not checked.
